// File: rtl/present_pkg.sv
// present_pkg: shared PRESENT constants, S-box table and stage occupancy states.
package present_pkg;
  localparam int STATE_W = 64;
  localparam int NIBBLES = 16;
  localparam logic [3:0] PRESENT_SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };
  typedef enum logic [1:0] {EMPTY, ONE, TWO} occ_t;
endpackage

// File: rtl/present_sbox4.sv
// present_sbox4: 4-bit combinational PRESENT S-box lookup.
module present_sbox4
  import present_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [3:0] sub
);
  assign sub = PRESENT_SBOX[nibble];
endmodule

// File: rtl/add_key_s_layer.sv
// add_key_s_layer: registered PRESENT addRoundKey + sBoxLayer stage with a two-entry skid buffer.
module add_key_s_layer #(
  parameter int STATE_W = 64
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_state,
  input  logic [STATE_W-1:0] in_round_key,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_state,
  output logic               out_last
);
  import present_pkg::*;
  if (STATE_W != 64) begin : g_width_check
    $error("add_key_s_layer supports only STATE_W = 64");
  end
  occ_t occ, occ_d;
  logic [STATE_W-1:0] x, sub, res, skid_state, main_d, skid_d;
  logic skid_last, main_last_d, skid_last_d, in_xfer, out_xfer;
  assign x = in_state ^ in_round_key;
  for (genvar i = 0; i < NIBBLES; i++) begin : g_sbox
    present_sbox4 u_sbox (.nibble(x[4*i +: 4]), .sub(sub[4*i +: 4]));
  end
  assign res = in_last ? x : sub;
  assign out_valid = occ != EMPTY;
  assign in_xfer = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  // Results are stored post-S-box, so a skid entry moves to main untouched.
  always_comb begin
    occ_d = occ;
    main_d = out_state;
    main_last_d = out_last;
    skid_d = skid_state;
    skid_last_d = skid_last;
    case (occ)
      EMPTY: if (in_xfer) begin
        occ_d = ONE;
        main_d = res;
        main_last_d = in_last;
      end
      ONE: if (in_xfer && !out_xfer) begin
        occ_d = TWO;
        skid_d = res;
        skid_last_d = in_last;
      end else if (in_xfer) begin
        main_d = res;
        main_last_d = in_last;
      end else if (out_xfer) begin
        occ_d = EMPTY;
      end
      TWO: if (out_xfer) begin
        occ_d = ONE;
        main_d = skid_state;
        main_last_d = skid_last;
      end
      default: occ_d = EMPTY;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ <= EMPTY;
      in_ready <= 1'b0;
      out_state <= '0;
      out_last <= 1'b0;
      skid_state <= '0;
      skid_last <= 1'b0;
    end else begin
      occ <= occ_d;
      in_ready <= occ_d != TWO;
      out_state <= main_d;
      out_last <= main_last_d;
      skid_state <= skid_d;
      skid_last <= skid_last_d;
    end
  end
endmodule
